stage_mem_sram: RTL and testbench

- Memory stage that sits directly downstream of the execute stage.
- Consumes the EXE results: ALU result as address, forwarded Rm as store data, control enables and destination.
- Performs 32-bit loads/stores on an external 16-bit SRAM as two half-word accesses, driven by a multi-cycle FSM.
- Drives `ready` low to freeze the pipeline while an access is in flight; outputs feed the MEM/WB pipeline register.

---
 rtl/stage_mem_sram_if.sv | 34 +++
 rtl/stage_mem_sram.sv | 90 +++++++++
 tb/tb_stage_mem_sram.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/stage_mem_sram_if.sv
// stage_mem_sram_if: EXE-side inputs, MEM/WB-side outputs and SRAM pins of the memory stage.
interface stage_mem_sram_if #(
    parameter int SRAM_ADDR_W = 18
);
    logic                   wbEnIn;
    logic                   memREnIn;
    logic                   memWEnIn;
    logic [31:0]            aluRes;
    logic [31:0]            valRm;
    logic [3:0]             dest;
    logic                   wbEnOut;
    logic                   memREnOut;
    logic [31:0]            aluResOut;
    logic [3:0]             destOut;
    logic [31:0]            memData;
    logic                   ready;
    logic [SRAM_ADDR_W-1:0] sramAddr;
    logic [15:0]            sramDqOut;
    logic [15:0]            sramDqIn;
    logic                   sramDqOe;
    logic                   sramWeN;

    modport slave (
        input  wbEnIn, memREnIn, memWEnIn, aluRes, valRm, dest, sramDqIn,
        output wbEnOut, memREnOut, aluResOut, destOut, memData, ready,
               sramAddr, sramDqOut, sramDqOe, sramWeN
    );

    modport master (
        output wbEnIn, memREnIn, memWEnIn, aluRes, valRm, dest, sramDqIn,
        input  wbEnOut, memREnOut, aluResOut, destOut, memData, ready,
               sramAddr, sramDqOut, sramDqOe, sramWeN
    );
endinterface

// File: rtl/stage_mem_sram.sv
// stage_mem_sram: memory stage doing 32-bit loads/stores as two half-word accesses on a 16-bit SRAM.
module stage_mem_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'd1024,
    parameter int          SRAM_ADDR_W = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    stage_mem_sram_if.slave  bus
);
    localparam int CW = $clog2(WAIT_CYCLES + 1) + 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [31:0]            r_mem_data;
    logic [SRAM_ADDR_W-1:0] r_addr;
    logic [15:0]            r_dq;
    logic                   r_we_n;
    logic                   r_oe;

    logic [SRAM_ADDR_W-2:0] w_word;
    logic                   w_req;
    logic                   w_st;
    logic                   w_last;

    // Word index of the offset from the data-memory base; low byte bits dropped.
    assign w_word = (SRAM_ADDR_W-1)'((bus.aluRes - ADDR_BASE) >> 2);
    assign w_req  = bus.memREnIn | bus.memWEnIn;
    assign w_st   = bus.memWEnIn;
    assign w_last = r_cnt == LAST;

    assign bus.wbEnOut   = bus.wbEnIn;
    assign bus.memREnOut = bus.memREnIn;
    assign bus.aluResOut = bus.aluRes;
    assign bus.destOut   = bus.dest;
    assign bus.memData   = r_mem_data;
    assign bus.sramAddr  = r_addr;
    assign bus.sramDqOut = r_dq;
    assign bus.sramWeN   = r_we_n;
    assign bus.sramDqOe  = r_oe;
    assign bus.ready     = (r_state == DONE) | ((r_state == IDLE) & ~w_req);

    // Pin values are loaded one edge ahead so they are valid for the whole phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_mem_data <= '0;
            r_addr     <= '0;
            r_dq       <= '0;
            r_we_n     <= 1'b1;
            r_oe       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_req) begin
                    r_state <= LO;
                    r_cnt   <= '0;
                    r_addr  <= {w_word, 1'b0};
                    r_dq    <= w_st ? bus.valRm[15:0] : '0;
                    r_we_n  <= ~w_st;
                    r_oe    <= w_st;
                end
                LO: if (w_last) begin
                    if (!w_st) r_mem_data[15:0] <= bus.sramDqIn;
                    r_state <= HI;
                    r_cnt   <= '0;
                    r_addr  <= {w_word, 1'b1};
                    r_dq    <= w_st ? bus.valRm[31:16] : '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                HI: if (w_last) begin
                    if (!w_st) r_mem_data[31:16] <= bus.sramDqIn;
                    r_state <= DONE;
                    r_cnt   <= '0;
                    r_addr  <= '0;
                    r_dq    <= '0;
                    r_we_n  <= 1'b1;
                    r_oe    <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stage_mem_sram.sv
// tb_stage_mem_sram: directed + random checks of the memory stage against a word-level reference model.
module tb_stage_mem_sram;
    logic clk = 1'b0;
    logic rst, rst0;
    always #5 clk = ~clk;

    stage_mem_sram_if #(.SRAM_ADDR_W(18)) b2();
    stage_mem_sram_if #(.SRAM_ADDR_W(18)) b0();

    stage_mem_sram #(.WAIT_CYCLES(2)) u2 (.clk(clk), .rst(rst),  .bus(b2));
    stage_mem_sram #(.WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst0), .bus(b0));

    logic        wb, mr, mw;
    logic [31:0] alu, vrm;
    logic [3:0]  dst;

    assign b2.wbEnIn = wb;  assign b2.memREnIn = mr; assign b2.memWEnIn = mw;
    assign b2.aluRes = alu; assign b2.valRm = vrm;   assign b2.dest = dst;
    assign b0.wbEnIn = wb;  assign b0.memREnIn = mr; assign b0.memWEnIn = mw;
    assign b0.aluRes = alu; assign b0.valRm = vrm;   assign b0.dest = dst;

    // Behavioural half-word SRAMs, one per DUT
    logic [15:0] sm2 [64] = '{default: 16'h0};
    logic [15:0] sm0 [64] = '{default: 16'h0};
    assign b2.sramDqIn = sm2[b2.sramAddr[5:0]];
    assign b0.sramDqIn = sm0[b0.sramAddr[5:0]];
    always @(posedge clk) if (!b2.sramWeN) sm2[b2.sramAddr[5:0]] <= b2.sramDqOut;
    always @(posedge clk) if (!b0.sramWeN) sm0[b0.sramAddr[5:0]] <= b0.sramDqOut;

    bit          sel0;
    logic        o_ready, o_we_n, o_oe, o_wb;
    logic [17:0] o_addr;
    logic [15:0] o_dq;
    logic [31:0] o_md, o_alu;
    logic [3:0]  o_dest;
    assign o_ready = sel0 ? b0.ready     : b2.ready;
    assign o_we_n  = sel0 ? b0.sramWeN   : b2.sramWeN;
    assign o_oe    = sel0 ? b0.sramDqOe  : b2.sramDqOe;
    assign o_wb    = sel0 ? b0.wbEnOut   : b2.wbEnOut;
    assign o_addr  = sel0 ? b0.sramAddr  : b2.sramAddr;
    assign o_dq    = sel0 ? b0.sramDqOut : b2.sramDqOut;
    assign o_md    = sel0 ? b0.memData   : b2.memData;
    assign o_alu   = sel0 ? b0.aluResOut : b2.aluResOut;
    assign o_dest  = sel0 ? b0.destOut   : b2.destOut;

    int          total = 0;
    int          bad = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] exp_md;
    bit          in_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_op(input int n, input logic [31:0] a, input logic [3:0] dd);
        wb = 1'b1; mr = 1'b0; mw = 1'b0; alu = a; dst = dd;
        #1;
        in_done = 0;
        for (int i = 0; i < n; i++) begin
            chk("idle_ready", o_ready, 1);
            chk("idle_we_n", o_we_n, 1);
            chk("idle_oe", o_oe, 0);
            chk("idle_alu", o_alu, a);
            chk("idle_dest", o_dest, dd);
            chk("idle_wb", o_wb, 1);
            chk("idle_md_hold", o_md, exp_md);
            tick;
        end
    endtask

    task automatic mem_op(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        int          ph  = (sel0 ? 0 : 2) + 1;
        logic [31:0] off = a - 32'd1024;
        int          key = int'((off >> 2) & 32'h1FFFF);
        logic [17:0] lo  = 18'(key * 2);
        logic [3:0]  dd  = 4'($urandom);
        wb = r; mr = r; mw = w; alu = a; vrm = d; dst = dd;
        #1;
        if (in_done) begin
            chk("done_ready_prev", o_ready, 1);
            tick;
        end
        chk("req_ready", o_ready, 0);
        chk("req_we_n", o_we_n, 1);
        for (int c = 0; c < 2 * ph; c++) begin
            tick;
            chk("busy_ready", o_ready, 0);
            chk("busy_addr", o_addr, c < ph ? lo : lo + 18'd1);
            chk("busy_we_n", o_we_n, w ? 0 : 1);
            chk("busy_oe", o_oe, w ? 1 : 0);
            if (w) chk("busy_dq", o_dq, c < ph ? d[15:0] : d[31:16]);
        end
        if (w) ref_mem[key] = d;
        else if (r) exp_md = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
        tick;
        chk("done_ready", o_ready, 1);
        chk("done_we_n", o_we_n, 1);
        chk("done_oe", o_oe, 0);
        chk("done_md", o_md, exp_md);
        chk("done_alu", o_alu, a);
        chk("done_dest", o_dest, dd);
        in_done = 1;
    endtask

    initial begin
        wb = 0; mr = 0; mw = 0; alu = 32'h55; vrm = 0; dst = 0;
        rst = 0; rst0 = 1; sel0 = 0; in_done = 0; exp_md = 0;
        #2 rst = 1;
        #1;
        chk("rst_we_n", o_we_n, 1);
        chk("rst_oe", o_oe, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_dq", o_dq, 0);
        chk("rst_md", o_md, 0);
        chk("rst_ready", o_ready, 1);
        alu = 32'h0BADF00D;
        #1 chk("rst_alu_pass", o_alu, 32'h0BADF00D);
        @(negedge clk) rst = 0;
        tick;

        idle_op(3, 32'h1234, 4'd5);
        mem_op(0, 1, 32'd1032, 32'hDEADBEEF);
        mem_op(1, 0, 32'd1032, 32'h0);
        idle_op(2, 32'h77, 4'd3);
        mem_op(1, 1, 32'd1036, 32'hCAFEF00D);
        mem_op(1, 0, 32'd1036, 32'h0);
        mem_op(0, 1, 32'd1020, 32'h12345678);
        mem_op(1, 0, 32'd1020, 32'h0);

        for (int i = 0; i < 24; i++) begin
            int          op = int'($urandom_range(0, 3));
            logic [31:0] a  = 32'd1024 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            if (op == 0) idle_op(int'($urandom_range(1, 3)), $urandom, 4'($urandom));
            else begin
                if ($urandom_range(0, 1) == 1) idle_op(1, a, 4'd0);
                mem_op(op != 2, op != 1, a, $urandom);
            end
        end

        idle_op(1, 32'h0, 4'd0);
        mw = 1; wb = 0; alu = 32'd1040; vrm = 32'h89ABCDEF;
        repeat (5) tick;
        #2 rst = 1;
        #1;
        exp_md = 0;
        chk("midrst_we_n", o_we_n, 1);
        chk("midrst_oe", o_oe, 0);
        chk("midrst_addr", o_addr, 0);
        chk("midrst_ready_req", o_ready, 0);
        chk("midrst_md", o_md, 0);
        mw = 0;
        #1 chk("midrst_ready_idle", o_ready, 1);
        @(negedge clk) rst = 0;
        tick;
        in_done = 0;

        sel0 = 1;
        @(negedge clk) rst0 = 0;
        tick;
        exp_md = 0;
        idle_op(1, 32'h0, 4'd0);
        mem_op(0, 1, 32'd1028, 32'hA5A55A5A);
        mem_op(1, 0, 32'd1028, 32'h0);
        idle_op(2, 32'h99, 4'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
